// File: rtl/fmc_ddr_burst.sv
// fmc_ddr_burst: splits one FMC transfer into DDR bursts of at most MAX_BURST beats; read data returns
// through a credit-protected FIFO. Define FMC_DDR_PERF_EN to add the PerfBusyCyc/PerfStallCyc counters.
module fmc_ddr_burst #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST     = 16,
  parameter int RD_FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  FMCDDR_CmdVld,
  output logic                  FMCDDR_CmdRdy,
  input  logic                  FMCDDR_CmdWr,
  input  logic [ADDR_WIDTH-1:0] FMCDDR_Addr,
  input  logic [LEN_WIDTH-1:0]  FMCDDR_Len,
  input  logic [DATA_WIDTH-1:0] FMCDDR_WrDat,
  input  logic                  FMCDDR_WrDatVld,
  output logic                  DDRFMC_WrDatRdy,
  output logic [DATA_WIDTH-1:0] DDRFMC_RdDat,
  output logic                  DDRFMC_RdDatVld,
  input  logic                  FMCDDR_RdDatRdy,
  output logic                  DDR_CmdVld,
  input  logic                  DDR_CmdRdy,
  output logic                  DDR_CmdWr,
  output logic [ADDR_WIDTH-1:0] DDR_CmdAddr,
  output logic [7:0]            DDR_CmdLen,
  output logic [DATA_WIDTH-1:0] DDR_WrDat,
  output logic                  DDR_WrDatVld,
  input  logic                  DDR_WrDatRdy,
  input  logic [DATA_WIDTH-1:0] DDR_RdDat,
  input  logic                  DDR_RdDatVld,
  output logic                  DDR_RdDatRdy,
  output logic                  Busy
`ifdef FMC_DDR_PERF_EN
  ,
  output logic [31:0]           PerfBusyCyc,
  output logic [31:0]           PerfStallCyc
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW    = $clog2(RD_FIFO_DEPTH);
  localparam int CW    = PW + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WCMD = 3'd1,
    S_WDAT = 3'd2,
    S_RCMD = 3'd3,
    S_RDRN = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [LEN_WIDTH-1:0]  r_delivered;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_fifo_cnt;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [RD_FIFO_DEPTH];
  logic                  r_cmd_vld;
  logic                  r_cmd_wr;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [7:0]            r_cmd_len;

  logic [LEN_WIDTH-1:0]  w_blen;
  logic [LEN_WIDTH-1:0]  w_remain_nxt;
  logic [CW-1:0]         w_blen_c;
  logic [CW-1:0]         w_out_add;
  logic [ADDR_WIDTH-1:0] w_addr_step;
  logic                  w_credit_ok;
  logic                  w_cmd_acc;
  logic                  w_wbeat;
  logic                  w_push;
  logic                  w_pop;

  assign w_blen       = (r_remain > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : r_remain;
  assign w_remain_nxt = r_remain - w_blen;
  assign w_blen_c     = CW'(w_blen);
  assign w_addr_step  = ADDR_WIDTH'(w_blen) * ADDR_WIDTH'(BYTES);
  // Credit counts FIFO slots not yet claimed by buffered or in-flight beats.
  assign w_credit_ok  = (r_fifo_cnt + r_outstanding + w_blen_c) <= CW'(RD_FIFO_DEPTH);
  assign w_cmd_acc    = r_cmd_vld & DDR_CmdRdy;
  assign w_wbeat      = (r_state == S_WDAT) & FMCDDR_WrDatVld & DDR_WrDatRdy;
  assign w_push       = DDR_RdDatVld;
  assign w_pop        = (r_fifo_cnt != CW'(0)) & FMCDDR_RdDatRdy;
  assign w_out_add    = (w_cmd_acc && (r_state == S_RCMD)) ? w_blen_c : CW'(0);

  assign FMCDDR_CmdRdy   = (r_state == S_IDLE);
  assign Busy            = (r_state != S_IDLE);
  assign DDR_CmdVld      = r_cmd_vld;
  assign DDR_CmdWr       = r_cmd_wr;
  assign DDR_CmdAddr     = r_cmd_addr;
  assign DDR_CmdLen      = r_cmd_len;
  assign DDR_WrDat       = FMCDDR_WrDat;
  assign DDR_WrDatVld    = (r_state == S_WDAT) & FMCDDR_WrDatVld;
  assign DDRFMC_WrDatRdy = (r_state == S_WDAT) & DDR_WrDatRdy;
  assign DDR_RdDatRdy    = 1'b1;
  assign DDRFMC_RdDat    = r_mem[r_rptr];
  assign DDRFMC_RdDatVld = (r_fifo_cnt != CW'(0));

  // Request capture, burst splitting and DDR command generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur_addr <= ADDR_WIDTH'(0);
      r_remain   <= LEN_WIDTH'(0);
      r_len      <= LEN_WIDTH'(0);
      r_beat_cnt <= LEN_WIDTH'(0);
      r_cmd_vld  <= 1'b0;
      r_cmd_wr   <= 1'b0;
      r_cmd_addr <= ADDR_WIDTH'(0);
      r_cmd_len  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (FMCDDR_CmdVld) begin
            r_cur_addr <= FMCDDR_Addr;
            r_remain   <= FMCDDR_Len;
            r_len      <= FMCDDR_Len;
            if (FMCDDR_Len != LEN_WIDTH'(0)) begin
              r_state <= FMCDDR_CmdWr ? S_WCMD : S_RCMD;
            end
          end
        end
        S_WCMD: begin
          if (!r_cmd_vld) begin
            r_cmd_vld  <= 1'b1;
            r_cmd_wr   <= 1'b1;
            r_cmd_addr <= r_cur_addr;
            r_cmd_len  <= 8'(w_blen - LEN_WIDTH'(1));
          end else if (DDR_CmdRdy) begin
            r_cmd_vld  <= 1'b0;
            r_cur_addr <= r_cur_addr + w_addr_step;
            r_remain   <= w_remain_nxt;
            r_beat_cnt <= w_blen;
            r_state    <= S_WDAT;
          end
        end
        S_WDAT: begin
          if (w_wbeat) begin
            r_beat_cnt <= r_beat_cnt - LEN_WIDTH'(1);
            if (r_beat_cnt == LEN_WIDTH'(1)) begin
              r_state <= (r_remain != LEN_WIDTH'(0)) ? S_WCMD : S_IDLE;
            end
          end
        end
        S_RCMD: begin
          if (!r_cmd_vld) begin
            if (w_credit_ok) begin
              r_cmd_vld  <= 1'b1;
              r_cmd_wr   <= 1'b0;
              r_cmd_addr <= r_cur_addr;
              r_cmd_len  <= 8'(w_blen - LEN_WIDTH'(1));
            end
          end else if (DDR_CmdRdy) begin
            r_cmd_vld  <= 1'b0;
            r_cur_addr <= r_cur_addr + w_addr_step;
            r_remain   <= w_remain_nxt;
            if (w_remain_nxt == LEN_WIDTH'(0)) begin
              r_state <= S_RDRN;
            end
          end
        end
        S_RDRN: begin
          if (w_pop && ((r_delivered + LEN_WIDTH'(1)) == r_len)) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cmd_vld <= 1'b0;
        end
      endcase
    end
  end

  // Read bookkeeping: beats delivered to FMC, beats still owed by DDR, FIFO occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delivered   <= LEN_WIDTH'(0);
      r_outstanding <= CW'(0);
      r_fifo_cnt    <= CW'(0);
      r_wptr        <= PW'(0);
      r_rptr        <= PW'(0);
    end else begin
      if (r_state == S_IDLE) begin
        r_delivered <= LEN_WIDTH'(0);
      end else if (w_pop) begin
        r_delivered <= r_delivered + LEN_WIDTH'(1);
      end
      r_outstanding <= r_outstanding + w_out_add - CW'(w_push);
      r_fifo_cnt    <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= DDR_RdDat;
    end
  end

`ifdef FMC_DDR_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;
  logic        w_any_hs;

  assign w_any_hs     = w_cmd_acc | w_wbeat | w_push | w_pop;
  assign PerfBusyCyc  = r_perf_busy;
  assign PerfStallCyc = r_perf_stall;

  // Saturating busy and stall cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (Busy && (r_perf_busy != 32'hFFFF_FFFF)) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
      if (Busy && !w_any_hs && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fmc_ddr_burst.sv
// Directed self-checking bench for fmc_ddr_burst: a DDR model answers read bursts with an
// address-derived pattern; commands, write beats and delivered read beats are checked against constants.
module tb_fmc_ddr_burst;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         FMCDDR_CmdVld, FMCDDR_CmdRdy, FMCDDR_CmdWr;
  logic [31:0]  FMCDDR_Addr;
  logic [15:0]  FMCDDR_Len;
  logic [127:0] FMCDDR_WrDat;
  logic         FMCDDR_WrDatVld, DDRFMC_WrDatRdy;
  logic [127:0] DDRFMC_RdDat;
  logic         DDRFMC_RdDatVld, FMCDDR_RdDatRdy;
  logic         DDR_CmdVld, DDR_CmdRdy, DDR_CmdWr;
  logic [31:0]  DDR_CmdAddr;
  logic [7:0]   DDR_CmdLen;
  logic [127:0] DDR_WrDat;
  logic         DDR_WrDatVld, DDR_WrDatRdy;
  logic [127:0] DDR_RdDat;
  logic         DDR_RdDatVld, DDR_RdDatRdy;
  logic         Busy;

  fmc_ddr_burst dut (
    .clk(clk), .rst_n(rst_n),
    .FMCDDR_CmdVld(FMCDDR_CmdVld), .FMCDDR_CmdRdy(FMCDDR_CmdRdy), .FMCDDR_CmdWr(FMCDDR_CmdWr),
    .FMCDDR_Addr(FMCDDR_Addr), .FMCDDR_Len(FMCDDR_Len),
    .FMCDDR_WrDat(FMCDDR_WrDat), .FMCDDR_WrDatVld(FMCDDR_WrDatVld), .DDRFMC_WrDatRdy(DDRFMC_WrDatRdy),
    .DDRFMC_RdDat(DDRFMC_RdDat), .DDRFMC_RdDatVld(DDRFMC_RdDatVld), .FMCDDR_RdDatRdy(FMCDDR_RdDatRdy),
    .DDR_CmdVld(DDR_CmdVld), .DDR_CmdRdy(DDR_CmdRdy), .DDR_CmdWr(DDR_CmdWr),
    .DDR_CmdAddr(DDR_CmdAddr), .DDR_CmdLen(DDR_CmdLen),
    .DDR_WrDat(DDR_WrDat), .DDR_WrDatVld(DDR_WrDatVld), .DDR_WrDatRdy(DDR_WrDatRdy),
    .DDR_RdDat(DDR_RdDat), .DDR_RdDatVld(DDR_RdDatVld), .DDR_RdDatRdy(DDR_RdDatRdy),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           occ = 0;
  int           ovf = 0;
  int           ddr_budget = 1000000;
  bit           toggle_en = 1'b0;
  bit           acc_req, ddr_push, fmc_pop, wsrc_take;
  bit           hold_pending = 1'b0;
  logic [40:0]  hold_val;
  logic [40:0]  cmd_q[$];
  logic [31:0]  rd_pend[$];
  logic [127:0] rd_got[$];
  logic [127:0] wr_got[$];
  logic [127:0] wsrc[$];
  logic [127:0] wexp[$];

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'd1};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, update the DDR/FMC models just after posedge.
  task automatic step();
    @(negedge clk);
    if (hold_pending) chk("cmd_hold", {DDR_CmdVld, DDR_CmdWr, DDR_CmdAddr, DDR_CmdLen}, {1'b1, hold_val});
    hold_pending = DDR_CmdVld && !DDR_CmdRdy;
    hold_val     = {DDR_CmdWr, DDR_CmdAddr, DDR_CmdLen};
    acc_req      = FMCDDR_CmdVld && FMCDDR_CmdRdy;
    if (DDR_CmdVld && DDR_CmdRdy) begin
      cmd_q.push_back({DDR_CmdWr, DDR_CmdAddr, DDR_CmdLen});
      if (!DDR_CmdWr)
        for (int i = 0; i <= int'(DDR_CmdLen); i++) rd_pend.push_back(DDR_CmdAddr + 32'(i * 16));
    end
    ddr_push  = DDR_RdDatVld && DDR_RdDatRdy;
    fmc_pop   = DDRFMC_RdDatVld && FMCDDR_RdDatRdy;
    wsrc_take = FMCDDR_WrDatVld && DDRFMC_WrDatRdy;
    if (fmc_pop) rd_got.push_back(DDRFMC_RdDat);
    if (DDR_WrDatVld && DDR_WrDatRdy) wr_got.push_back(DDR_WrDat);
    if (ddr_push && !fmc_pop && occ >= 32) ovf++;
    occ = occ + (ddr_push ? 1 : 0) - (fmc_pop ? 1 : 0);
    @(posedge clk);
    #1;
    if (acc_req) FMCDDR_CmdVld = 1'b0;
    if (ddr_push) begin
      void'(rd_pend.pop_front());
      ddr_budget--;
    end
    if (wsrc_take) void'(wsrc.pop_front());
    DDR_RdDatVld    = (rd_pend.size() > 0) && (ddr_budget > 0);
    DDR_RdDat       = DDR_RdDatVld ? pat(rd_pend[0]) : 128'd0;
    FMCDDR_WrDatVld = (wsrc.size() > 0);
    FMCDDR_WrDat    = FMCDDR_WrDatVld ? wsrc[0] : 128'd0;
    if (toggle_en) begin
      DDR_WrDatRdy = ~DDR_WrDatRdy;
      DDR_CmdRdy   = ~DDR_CmdRdy;
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] a, input logic [15:0] l,
                        output int cycles);
    int n = 0;
    FMCDDR_CmdVld = 1'b1;
    FMCDDR_CmdWr  = wr;
    FMCDDR_Addr   = a;
    FMCDDR_Len    = l;
    acc_req       = 1'b0;
    do begin
      step();
      n++;
    end while (!acc_req && n < 100);
    FMCDDR_CmdVld = 1'b0;
    chk({tag, "_accept"}, 128'(acc_req), 128'd1);
    cycles = n;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 128'(Busy), 128'd0);
  endtask

  task automatic check_rd(input string tag, input logic [31:0] base, input int cnt);
    int bad = 0;
    chk({tag, "_rd_count"}, 128'(rd_got.size()), 128'(cnt));
    for (int i = 0; i < rd_got.size(); i++)
      if (rd_got[i] !== pat(base + 32'(i * 16))) bad++;
    chk({tag, "_rd_data_bad"}, 128'(bad), 128'd0);
  endtask

  task automatic check_wr(input string tag);
    int bad = 0;
    chk({tag, "_wr_count"}, 128'(wr_got.size()), 128'(wexp.size()));
    for (int i = 0; i < wr_got.size() && i < wexp.size(); i++)
      if (wr_got[i] !== wexp[i]) bad++;
    chk({tag, "_wr_data_bad"}, 128'(bad), 128'd0);
  endtask

  task automatic clear_logs();
    cmd_q.delete();
    rd_got.delete();
    wr_got.delete();
    wexp.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    FMCDDR_CmdVld = 1'b0; FMCDDR_CmdWr = 1'b0; FMCDDR_Addr = 32'd0; FMCDDR_Len = 16'd0;
    FMCDDR_WrDat = 128'd0; FMCDDR_WrDatVld = 1'b0; FMCDDR_RdDatRdy = 1'b1;
    DDR_CmdRdy = 1'b1; DDR_WrDatRdy = 1'b1; DDR_RdDat = 128'd0; DDR_RdDatVld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdrdy", 128'(FMCDDR_CmdRdy), 128'd1);
    chk("rst_busy", 128'(Busy), 128'd0);
    chk("rst_ddr_cmdvld", 128'(DDR_CmdVld), 128'd0);
    chk("rst_ddr_cmd_fields", 128'({DDR_CmdWr, DDR_CmdAddr, DDR_CmdLen}), 128'd0);
    chk("rst_rdvld", 128'(DDRFMC_RdDatVld), 128'd0);
    chk("rst_wrvld", 128'(DDR_WrDatVld), 128'd0);
    chk("rst_ddr_rdrdy", 128'(DDR_RdDatRdy), 128'd1);
    rst_n = 1'b1;
    step();

    // Read of 40 beats split into 16+16+8.
    clear_logs();
    do_req("rd40", 1'b0, 32'h0000_1000, 16'd40, cyc);
    wait_idle("rd40");
    chk("rd40_ncmd", 128'(cmd_q.size()), 128'd3);
    if (cmd_q.size() == 3) begin
      chk("rd40_cmd0", 128'(cmd_q[0]), 128'({1'b0, 32'h0000_1000, 8'd15}));
      chk("rd40_cmd1", 128'(cmd_q[1]), 128'({1'b0, 32'h0000_1100, 8'd15}));
      chk("rd40_cmd2", 128'(cmd_q[2]), 128'({1'b0, 32'h0000_1200, 8'd7}));
    end
    check_rd("rd40", 32'h0000_1000, 40);

    // Zero-length request: one-cycle accept, no DDR traffic.
    clear_logs();
    do_req("len0", 1'b0, 32'h0000_5000, 16'd0, cyc);
    chk("len0_accept_cycles", 128'(cyc), 128'd1);
    chk("len0_busy", 128'(Busy), 128'd0);
    repeat (5) step();
    chk("len0_ncmd", 128'(cmd_q.size()), 128'd0);
    chk("len0_busy_later", 128'(Busy), 128'd0);

    // Write of 16 beats with toggling DDR readiness.
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      wsrc.push_back({32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 7), 32'(i), 32'hFFFF_0000 | 32'(i)});
      wexp.push_back({32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 7), 32'(i), 32'hFFFF_0000 | 32'(i)});
    end
    toggle_en = 1'b1;
    do_req("wr16", 1'b1, 32'h0000_0000, 16'd16, cyc);
    wait_idle("wr16");
    toggle_en = 1'b0; DDR_CmdRdy = 1'b1; DDR_WrDatRdy = 1'b1;
    chk("wr16_ncmd", 128'(cmd_q.size()), 128'd1);
    if (cmd_q.size() == 1) chk("wr16_cmd0", 128'(cmd_q[0]), 128'({1'b1, 32'h0000_0000, 8'd15}));
    check_wr("wr16");

    // Read of 64 beats with FMC stalled: credit limits to two bursts.
    clear_logs();
    FMCDDR_RdDatRdy = 1'b0;
    do_req("rd64", 1'b0, 32'h0000_2000, 16'd64, cyc);
    repeat (150) step();
    chk("rd64_ncmd_stalled", 128'(cmd_q.size()), 128'd2);
    chk("rd64_cmdvld_stalled", 128'(DDR_CmdVld), 128'd0);
    chk("rd64_fifo_full", 128'(occ), 128'd32);
    chk("rd64_rdvld_stalled", 128'(DDRFMC_RdDatVld), 128'd1);
    FMCDDR_RdDatRdy = 1'b1;
    wait_idle("rd64");
    chk("rd64_ncmd", 128'(cmd_q.size()), 128'd4);
    if (cmd_q.size() == 4) begin
      chk("rd64_cmd2", 128'(cmd_q[2]), 128'({1'b0, 32'h0000_2200, 8'd15}));
      chk("rd64_cmd3", 128'(cmd_q[3]), 128'({1'b0, 32'h0000_2300, 8'd15}));
    end
    check_rd("rd64", 32'h0000_2000, 64);

    // Write across the top of the address space.
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      wsrc.push_back({4{32'hA5A5_0000 + 32'(i * 3)}});
      wexp.push_back({4{32'hA5A5_0000 + 32'(i * 3)}});
    end
    do_req("wrap", 1'b1, 32'hFFFF_FFF0, 16'd20, cyc);
    wait_idle("wrap");
    chk("wrap_ncmd", 128'(cmd_q.size()), 128'd2);
    if (cmd_q.size() == 2) begin
      chk("wrap_cmd0", 128'(cmd_q[0]), 128'({1'b1, 32'hFFFF_FFF0, 8'd15}));
      chk("wrap_cmd1", 128'(cmd_q[1]), 128'({1'b1, 32'h0000_00F0, 8'd3}));
    end
    check_wr("wrap");

    // Reset while in the read-command phase with 10 beats outstanding.
    clear_logs();
    FMCDDR_RdDatRdy = 1'b0;
    ddr_budget = 0;
    do_req("abort", 1'b0, 32'h0000_4000, 16'd40, cyc);
    repeat (30) step();
    chk("abort_ncmd", 128'(cmd_q.size()), 128'd2);
    ddr_budget = 22;
    repeat (40) step();
    chk("abort_fifo_occ", 128'(occ), 128'd22);
    chk("abort_busy_before", 128'(Busy), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cmdrdy", 128'(FMCDDR_CmdRdy), 128'd1);
    chk("abort_vlds", 128'({DDR_CmdVld, DDRFMC_RdDatVld, DDR_WrDatVld}), 128'd0);
    chk("abort_busy", 128'(Busy), 128'd0);
    @(posedge clk);
    #1;
    rd_pend.delete();
    DDR_RdDatVld = 1'b0;
    occ = 0;
    hold_pending = 1'b0;
    ddr_budget = 1000000;
    FMCDDR_RdDatRdy = 1'b1;
    rst_n = 1'b1;
    clear_logs();
    step();
    do_req("post", 1'b0, 32'h0000_3000, 16'd8, cyc);
    wait_idle("post");
    chk("post_ncmd", 128'(cmd_q.size()), 128'd1);
    if (cmd_q.size() == 1) chk("post_cmd0", 128'(cmd_q[0]), 128'({1'b0, 32'h0000_3000, 8'd7}));
    check_rd("post", 32'h0000_3000, 8);

    chk("fifo_no_overflow", 128'(ovf), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
